execute_stage: RTL and testbench



---
 rtl/execute_stage.sv | 182 ++++++++++++++++++
 tb/tb_execute_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// execute_stage: the ID/EX register, the one-hot ALU, jump/branch resolution,
// the EX/MEM register, and the hazard and forwarding buses for the
// five-stage RV32I core.
//
// Valid semantics: a slot carries a real instruction only while its valid bit
// is 1. There is no backpressure toward decode other than the bubble. A bubble
// (decode stall or a redirect out of EX) loads valid=0 and clears every
// side-effect field of the incoming instruction. EX/MEM is never stalled, so
// the EX-resident instruction always advances on the next edge.
module execute_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic            stall_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] op1_data,
    input  logic [XLEN-1:0] op2_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    input  logic            rd_wen_in,
    input  logic [18:0]     exe_fun,
    input  logic            mem_we_in,
    input  logic            mem_re_in,
    input  logic [2:0]      wb_sel_in,
    input  logic [3:0]      csr_cmd_in,
    input  logic [11:0]     csr_addr_in,
    output logic            br_flag,
    output logic [XLEN-1:0] br_target,
    output logic [5:0]      exe_id_data_bus,
    output logic            exmem_valid,
    output logic [XLEN-1:0] exmem_alu_out,
    output logic [XLEN-1:0] exmem_rs2_data,
    output logic [4:0]      exmem_rd,
    output logic            exmem_rd_wen,
    output logic            exmem_mem_we,
    output logic            exmem_mem_re,
    output logic [2:0]      exmem_wb_sel,
    output logic [3:0]      exmem_csr_cmd,
    output logic [11:0]     exmem_csr_addr,
    output logic [XLEN-1:0] exmem_pc,
    output logic [XLEN+5:0] exe_mem_regfile
);

    // ID/EX register contents
    logic            ie_valid;
    logic [XLEN-1:0] ie_pc;
    logic [XLEN-1:0] ie_op1;
    logic [XLEN-1:0] ie_op2;
    logic [XLEN-1:0] ie_rs2;
    logic [4:0]      ie_rd;
    logic            ie_rd_wen;
    logic [18:0]     ie_fun;
    logic            ie_mem_we;
    logic            ie_mem_re;
    logic [2:0]      ie_wb_sel;
    logic [3:0]      ie_csr_cmd;
    logic [11:0]     ie_csr_addr;

    logic            bubble;
    logic            jal;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] result;
    logic [4:0]      shamt;

    // A redirect kills the younger instruction decode is presenting now.
    assign bubble = stall_in | br_flag;

    // ID/EX capture; a bubble keeps operands but strips all side effects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie_valid    <= 1'b0;
            ie_pc       <= '0;
            ie_op1      <= '0;
            ie_op2      <= '0;
            ie_rs2      <= '0;
            ie_rd       <= '0;
            ie_rd_wen   <= 1'b0;
            ie_fun      <= '0;
            ie_mem_we   <= 1'b0;
            ie_mem_re   <= 1'b0;
            ie_wb_sel   <= '0;
            ie_csr_cmd  <= '0;
            ie_csr_addr <= '0;
        end else begin
            ie_pc       <= pc_in;
            ie_op1      <= op1_data;
            ie_op2      <= op2_data;
            ie_rs2      <= rs2_data;
            ie_rd       <= rd_in;
            ie_csr_addr <= csr_addr_in;
            if (bubble) begin
                ie_valid   <= 1'b0;
                ie_rd_wen  <= 1'b0;
                ie_fun     <= '0;
                ie_mem_we  <= 1'b0;
                ie_mem_re  <= 1'b0;
                ie_wb_sel  <= '0;
                ie_csr_cmd <= '0;
            end else begin
                ie_valid   <= id_valid;
                ie_rd_wen  <= rd_wen_in;
                ie_fun     <= exe_fun;
                ie_mem_we  <= mem_we_in;
                ie_mem_re  <= mem_re_in;
                ie_wb_sel  <= wb_sel_in;
                ie_csr_cmd <= csr_cmd_in;
            end
        end
    end

    assign sum   = ie_op1 + ie_op2;
    assign shamt = ie_op2[4:0];

    // One-hot ALU; the if-chain makes the highest set bit win.
    always_comb begin
        alu_res = '0;
        if (ie_fun[18])      alu_res = sum;
        else if (ie_fun[17]) alu_res = ie_op1 - ie_op2;
        else if (ie_fun[16]) alu_res = ie_op1 & ie_op2;
        else if (ie_fun[15]) alu_res = ie_op1 | ie_op2;
        else if (ie_fun[14]) alu_res = ie_op1 ^ ie_op2;
        else if (ie_fun[13]) alu_res = ie_op1 << shamt;
        else if (ie_fun[12]) alu_res = ie_op1 >> shamt;
        else if (ie_fun[11]) alu_res = $unsigned($signed(ie_op1) >>> shamt);
        else if (ie_fun[10]) alu_res = {{(XLEN-1){1'b0}}, ($signed(ie_op1) < $signed(ie_op2))};
        else if (ie_fun[9])  alu_res = {{(XLEN-1){1'b0}}, (ie_op1 < ie_op2)};
        else if (|ie_fun[8:2]) alu_res = sum;   // branch/JALR address
        else if (ie_fun[1])  alu_res = ie_op1;
        else if (ie_fun[0])  alu_res = '0;      // ecall produces no value
    end

    // JAL is signalled only by writing back PC+4 without the JALR bit.
    assign jal     = ie_wb_sel[1] & ~ie_fun[2];
    assign br_flag = ie_valid & ((|ie_fun[8:3]) | ie_fun[2] | jal);

    // Target is forced to 0 when not redirecting; JALR clears bit 0.
    always_comb begin
        br_target = '0;
        if (br_flag) br_target = sum & ~{{(XLEN-1){1'b0}}, ie_fun[2]};
    end

    assign result          = ie_wb_sel[1] ? (ie_pc + {{(XLEN-3){1'b0}}, 3'd4}) : alu_res;
    assign exe_id_data_bus = {ie_valid & ie_mem_re, ie_rd};

    // EX/MEM register: advances every cycle regardless of decode stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exmem_valid    <= 1'b0;
            exmem_alu_out  <= '0;
            exmem_rs2_data <= '0;
            exmem_rd       <= '0;
            exmem_rd_wen   <= 1'b0;
            exmem_mem_we   <= 1'b0;
            exmem_mem_re   <= 1'b0;
            exmem_wb_sel   <= '0;
            exmem_csr_cmd  <= '0;
            exmem_csr_addr <= '0;
            exmem_pc       <= '0;
        end else begin
            exmem_valid    <= ie_valid;
            exmem_alu_out  <= result;
            exmem_rs2_data <= ie_rs2;
            exmem_rd       <= ie_rd;
            exmem_rd_wen   <= ie_rd_wen;
            exmem_mem_we   <= ie_mem_we;
            exmem_mem_re   <= ie_mem_re;
            exmem_wb_sel   <= ie_wb_sel;
            exmem_csr_cmd  <= ie_csr_cmd;
            exmem_csr_addr <= ie_csr_addr;
            exmem_pc       <= ie_pc;
        end
    end

    // Loads are not forwardable from EX/MEM (data not yet read); x0 never is.
    assign exe_mem_regfile = {exmem_rd,
                              exmem_valid & exmem_rd_wen & ~exmem_mem_re & (exmem_rd != 5'd0),
                              exmem_alu_out};

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed cases plus randomized traffic. A driver
// issues one instruction per cycle and pushes the expected EX/MEM record; a
// monitor pops and compares whenever exmem_valid is seen.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, stall_in;
    logic [31:0] pc_in, op1_data, op2_data, rs2_data;
    logic [4:0]  rd_in;
    logic        rd_wen_in;
    logic [18:0] exe_fun;
    logic        mem_we_in, mem_re_in;
    logic [2:0]  wb_sel_in;
    logic [3:0]  csr_cmd_in;
    logic [11:0] csr_addr_in;
    logic        br_flag;
    logic [31:0] br_target;
    logic [5:0]  exe_id_data_bus;
    logic        exmem_valid;
    logic [31:0] exmem_alu_out, exmem_rs2_data, exmem_pc;
    logic [4:0]  exmem_rd;
    logic        exmem_rd_wen, exmem_mem_we, exmem_mem_re;
    logic [2:0]  exmem_wb_sel;
    logic [3:0]  exmem_csr_cmd;
    logic [11:0] exmem_csr_addr;
    logic [37:0] exe_mem_regfile;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        rd_wen;
        logic        mem_we;
        logic        mem_re;
        logic [2:0]  wb;
        logic [3:0]  csr;
        logic [11:0] caddr;
    } exp_t;

    exp_t exp_q[$];

    // Model of the EX slot: does the instruction now in EX redirect fetch?
    logic m_redirect = 1'b0;

    execute_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .stall_in(stall_in),
        .pc_in(pc_in), .op1_data(op1_data), .op2_data(op2_data), .rs2_data(rs2_data),
        .rd_in(rd_in), .rd_wen_in(rd_wen_in), .exe_fun(exe_fun),
        .mem_we_in(mem_we_in), .mem_re_in(mem_re_in), .wb_sel_in(wb_sel_in),
        .csr_cmd_in(csr_cmd_in), .csr_addr_in(csr_addr_in),
        .br_flag(br_flag), .br_target(br_target), .exe_id_data_bus(exe_id_data_bus),
        .exmem_valid(exmem_valid), .exmem_alu_out(exmem_alu_out),
        .exmem_rs2_data(exmem_rs2_data), .exmem_rd(exmem_rd), .exmem_rd_wen(exmem_rd_wen),
        .exmem_mem_we(exmem_mem_we), .exmem_mem_re(exmem_mem_re), .exmem_wb_sel(exmem_wb_sel),
        .exmem_csr_cmd(exmem_csr_cmd), .exmem_csr_addr(exmem_csr_addr), .exmem_pc(exmem_pc),
        .exe_mem_regfile(exe_mem_regfile)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference ALU: find the highest set command bit, then apply plain arithmetic.
    function automatic logic [31:0] ref_alu(input logic [18:0] fun, input logic [31:0] a,
                                            input logic [31:0] b);
        int top = -1;
        int sh = int'(b[4:0]);
        logic [31:0] ones = 32'hFFFF_FFFF;
        for (int i = 0; i < 19; i++) if (fun[i]) top = i;
        case (top)
            18: return a + b;
            17: return a - b;
            16: return a & b;
            15: return a | b;
            14: return a ^ b;
            13: return a << sh;
            12: return a >> sh;
            11: return (a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0);
            10: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            9:  return (a < b) ? 32'd1 : 32'd0;
            8, 7, 6, 5, 4, 3, 2: return a + b;
            1:  return a;
            default: return 32'd0;
        endcase
    endfunction

    // Drive one instruction slot, clock it in, then check the EX-stage outputs.
    task automatic step(input logic v, input logic st, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] rs2,
                        input logic [4:0] rd, input logic rwe, input logic [18:0] fun,
                        input logic mwe, input logic mre, input logic [2:0] wb,
                        input logic [3:0] csr, input logic [11:0] caddr);
        logic accept;
        logic exp_br;
        logic [31:0] exp_tgt;
        exp_t e;
        id_valid = v; stall_in = st; pc_in = pc; op1_data = a; op2_data = b;
        rs2_data = rs2; rd_in = rd; rd_wen_in = rwe; exe_fun = fun;
        mem_we_in = mwe; mem_re_in = mre; wb_sel_in = wb; csr_cmd_in = csr;
        csr_addr_in = caddr;
        accept = v & ~st & ~m_redirect;
        @(posedge clk);
        #1;
        exp_br  = accept & ((|fun[8:2]) | (wb[1] & ~fun[2]));
        exp_tgt = exp_br ? ((a + b) & ~{31'd0, fun[2]}) : 32'd0;
        m_redirect = exp_br;
        if (accept) begin
            e.pc = pc; e.alu = wb[1] ? pc + 32'd4 : ref_alu(fun, a, b);
            e.rs2 = rs2; e.rd = rd; e.rd_wen = rwe; e.mem_we = mwe; e.mem_re = mre;
            e.wb = wb; e.csr = csr; e.caddr = caddr;
            exp_q.push_back(e);
        end
        chk("br_flag", {63'd0, br_flag}, {63'd0, exp_br});
        chk("br_target", {32'd0, br_target}, {32'd0, exp_tgt});
        chk("hazard_bus", {58'd0, exe_id_data_bus}, {58'd0, accept & mre, rd});
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 19'd0, 1'b0, 1'b0,
             3'd0, 4'd0, 12'd0);
    endtask

    // Simple ALU op: valid, writes rd, no memory, no CSR.
    task automatic alu_op(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [18:0] fun);
        step(1'b1, 1'b0, pc, a, b, 32'h5A5A_0000 ^ pc, rd, 1'b1, fun, 1'b0, 1'b0,
             3'd0, 4'd0, 12'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_br_flag"}, {63'd0, br_flag}, 64'd0);
        chk({tag, "_br_target"}, {32'd0, br_target}, 64'd0);
        chk({tag, "_hazard_bus"}, {58'd0, exe_id_data_bus}, 64'd0);
        chk({tag, "_exmem_valid"}, {63'd0, exmem_valid}, 64'd0);
        chk({tag, "_exmem_alu"}, {32'd0, exmem_alu_out}, 64'd0);
        chk({tag, "_exmem_pc"}, {32'd0, exmem_pc}, 64'd0);
        chk({tag, "_fwd_bus"}, {26'd0, exe_mem_regfile}, 64'd0);
    endtask

    // Monitor / scoreboard: every valid EX/MEM record must match the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && exmem_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_exmem_valid", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("exmem_pc", {32'd0, exmem_pc}, {32'd0, e.pc});
                    chk("exmem_alu_out", {32'd0, exmem_alu_out}, {32'd0, e.alu});
                    chk("exmem_rs2", {32'd0, exmem_rs2_data}, {32'd0, e.rs2});
                    chk("exmem_ctrl", {38'd0, exmem_rd, exmem_rd_wen, exmem_mem_we, exmem_mem_re,
                                       exmem_wb_sel, exmem_csr_cmd, exmem_csr_addr},
                        {38'd0, e.rd, e.rd_wen, e.mem_we, e.mem_re, e.wb, e.csr, e.caddr});
                    chk("fwd_bus", {26'd0, exe_mem_regfile},
                        {26'd0, e.rd, e.rd_wen & ~e.mem_re & (e.rd != 5'd0), e.alu});
                end
            end
        end
    end

    // Main stimulus
    initial begin
        logic [18:0] f;
        logic [2:0]  wb;
        logic [31:0] a, b;
        int k;

        rst = 1'b1;
        id_valid = 1'b0; stall_in = 1'b0; pc_in = '0; op1_data = '0; op2_data = '0;
        rs2_data = '0; rd_in = '0; rd_wen_in = 1'b0; exe_fun = '0; mem_we_in = 1'b0;
        mem_re_in = 1'b0; wb_sel_in = '0; csr_cmd_in = '0; csr_addr_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ALU sweep with results checked two cycles after acceptance
        alu_op(32'h10, 32'hFFFF_FFFF, 32'd1, 5'd3, 19'd1 << 18);        // ADD
        alu_op(32'h14, 32'h8000_0000, 32'd4, 5'd4, 19'd1 << 11);        // SRA
        chk("add_wrap", {32'd0, exmem_alu_out}, 64'd0);
        alu_op(32'h18, 32'hFFFF_FFFF, 32'd1, 5'd6, 19'd1 << 10);        // SLT
        chk("sra_neg", {32'd0, exmem_alu_out}, {32'd0, 32'hF800_0000});
        alu_op(32'h1C, 32'hFFFF_FFFF, 32'd1, 5'd7, 19'd1 << 9);         // SLTU
        chk("slt_signed", {32'd0, exmem_alu_out}, 64'd1);
        alu_op(32'h20, 32'h1234_5678, 32'd0, 5'd8, 19'd1 << 1);         // COPY1
        chk("sltu_unsigned", {32'd0, exmem_alu_out}, 64'd0);
        alu_op(32'h24, 32'h0000_00F0, 32'h0000_0F0F, 5'd9, (19'd1 << 16) | (19'd1 << 9));

        // Taken BEQ: one-cycle redirect, the next instruction is discarded
        step(1'b1, 1'b0, 32'h100, 32'h100, 32'h20, 32'd0, 5'd0, 1'b0, 19'd1 << 8,
             1'b0, 1'b0, 3'd0, 4'd0, 12'd0);
        chk("beq_flag", {63'd0, br_flag}, 64'd1);
        chk("beq_target", {32'd0, br_target}, 64'h120);
        alu_op(32'h104, 32'd1, 32'd2, 5'd10, 19'd1 << 18);
        chk("beq_flag_one_cycle", {63'd0, br_flag}, 64'd0);
        alu_op(32'h120, 32'd3, 32'd4, 5'd11, 19'd1 << 18);

        // JALR to rd=1 then rd=0
        step(1'b1, 1'b0, 32'h200, 32'h2003, 32'd0, 32'd0, 5'd1, 1'b1, 19'd1 << 2,
             1'b0, 1'b0, 3'b010, 4'd0, 12'd0);
        chk("jalr_target", {32'd0, br_target}, 64'h2002);
        idle();
        chk("jalr_link", {32'd0, exmem_alu_out}, 64'h204);
        chk("jalr_fwd_we", {63'd0, exe_mem_regfile[32]}, 64'd1);
        step(1'b1, 1'b0, 32'h2002, 32'h3000, 32'd8, 32'd0, 5'd0, 1'b1, 19'd1 << 2,
             1'b0, 1'b0, 3'b010, 4'd0, 12'd0);
        idle();
        chk("jalr_x0_fwd_we", {63'd0, exe_mem_regfile[32]}, 64'd0);

        // Load-use: load to x5, decode stalls one cycle
        step(1'b1, 1'b0, 32'h300, 32'h1000, 32'h8, 32'd0, 5'd5, 1'b1, 19'd1 << 18,
             1'b0, 1'b1, 3'b100, 4'd0, 12'd0);
        chk("load_hazard_bus", {58'd0, exe_id_data_bus}, 64'h25);
        step(1'b1, 1'b1, 32'h304, 32'd0, 32'd0, 32'd0, 5'd5, 1'b1, 19'd1 << 18,
             1'b0, 1'b0, 3'd0, 4'd0, 12'd0);
        chk("stall_bubble_bus", {58'd0, exe_id_data_bus}, 64'h05);
        chk("load_fwd_we", {63'd0, exe_mem_regfile[32]}, 64'd0);
        alu_op(32'h304, 32'd7, 32'd9, 5'd5, 19'd1 << 18);

        // Stall and a taken branch in the same cycle
        step(1'b1, 1'b0, 32'h400, 32'h400, 32'h40, 32'd0, 5'd0, 1'b0, 19'd1 << 7,
             1'b0, 1'b0, 3'd0, 4'd0, 12'd0);
        step(1'b1, 1'b1, 32'h404, 32'd1, 32'd1, 32'd0, 5'd12, 1'b1, 19'd1 << 18,
             1'b0, 1'b0, 3'd0, 4'd0, 12'd0);
        alu_op(32'h440, 32'd5, 32'd6, 5'd13, 19'd1 << 17);
        alu_op(32'h444, 32'd5, 32'd6, 5'd14, 19'd1 << 15);

        // Reset mid-stream discards both stages at once
        alu_op(32'h500, 32'd1, 32'd1, 5'd15, 19'd1 << 18);
        alu_op(32'h504, 32'd1, 32'd1, 5'd16, 19'd1 << 18);
        id_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        m_redirect = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("post_reset_exmem_valid", {63'd0, exmem_valid}, 64'd0);
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            k = int'($urandom_range(0, 99));
            wb = (k < 10) ? 3'b010 : (($urandom_range(0, 3) == 0) ? 3'b100 : 3'b000);
            if (k < 5) f = 19'd1 << 2;                                  // JALR
            else if (k < 10) f = 19'd1 << 18;                           // JAL
            else if (k < 20) f = 19'd1 << $urandom_range(3, 8);         // branch
            else if (k < 30) f = (19'd1 << $urandom_range(9, 18)) | (19'd1 << $urandom_range(0, 18));
            else begin
                k = int'($urandom_range(0, 11));
                f = (k < 2) ? (19'd1 << k) : (19'd1 << (k + 7));
            end
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            step($urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0, $urandom, a, b,
                 $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), f,
                 1'($urandom_range(0, 1)), wb[2], wb, 4'($urandom_range(0, 15)),
                 12'($urandom));
        end

        // Drain
        repeat (3) idle();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
